// File: rtl/npu_synchronization_defines.sv
// Shared sync-core types.
//  barrier_t              : barrier identifier carried in account messages
//  cnt_barrier_t          : participant count (0..TILE_COUNT)
//  tile_id_t              : source tile index
//  sync_account_message_t : one account (arrival) message from stage1
//  sync_barrier_entry_t   : one barrier accounting record {busy, cnt, cnt_max, tile_mask}
`ifndef BARRIER_NUMBER
`define BARRIER_NUMBER 16
`endif
`ifndef TILE_COUNT
`define TILE_COUNT 8
`endif

package npu_synchronization_defines;

    localparam int BARRIER_NUMBER = `BARRIER_NUMBER;
    localparam int TILE_COUNT     = `TILE_COUNT;
    localparam int BARRIER_ID_W   = 8;
    localparam int TILE_ID_W      = (TILE_COUNT > 1) ? $clog2(TILE_COUNT) : 1;
    // One extra bit so a count equal to TILE_COUNT is representable.
    localparam int CNT_W          = $clog2(TILE_COUNT) + 1;

    typedef logic [BARRIER_ID_W-1:0] barrier_t;
    typedef logic [CNT_W-1:0]        cnt_barrier_t;
    typedef logic [TILE_ID_W-1:0]    tile_id_t;
    typedef logic [TILE_COUNT-1:0]   tile_mask_t;

    typedef struct packed {
        barrier_t     id_barrier;
        cnt_barrier_t cnt_setup;
        tile_id_t     tile_id_source;
    } sync_account_message_t;

    typedef struct packed {
        logic         busy;
        cnt_barrier_t cnt;
        cnt_barrier_t cnt_max;
        tile_mask_t   tile_mask;
    } sync_barrier_entry_t;

    // One-hot tile mask for a single source tile.
    function automatic tile_mask_t tile_onehot(input tile_id_t src);
        tile_mask_t m;
        m      = '0;
        m[src] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/synchronization_barrier_table.sv
// Per-barrier accounting table.
//  clk      in  : clock
//  clear    in  : synchronous, active-high; clears every busy bit and tile mask
//  rd_idx   in  : asynchronous read index
//  rd_entry out : entry at rd_idx (combinational)
//  wr_en    in  : write strobe
//  wr_idx   in  : write index
//  wr_entry in  : data written at the end of the cycle
// cnt / cnt_max are not cleared: they are only meaningful while busy is set.
module synchronization_barrier_table
    import npu_synchronization_defines::*;
#(
    parameter int BARRIER_NUMBER = npu_synchronization_defines::BARRIER_NUMBER,
    parameter int IDX_W          = (BARRIER_NUMBER > 1) ? $clog2(BARRIER_NUMBER) : 1
) (
    input  logic                clk,
    input  logic                clear,
    input  logic [IDX_W-1:0]    rd_idx,
    output sync_barrier_entry_t rd_entry,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  sync_barrier_entry_t wr_entry
);

    sync_barrier_entry_t entry_arr [BARRIER_NUMBER];

    genvar gi;
    generate
        for (gi = 0; gi < BARRIER_NUMBER; gi++) begin : g_entry
            sync_barrier_entry_t entry_q;
            sync_barrier_entry_t entry_d;

            always_comb begin
                entry_d = entry_q;
                if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    entry_d = wr_entry;
                end
            end

            always_ff @(posedge clk) begin
                if (clear) begin
                    entry_q.busy      <= 1'b0;
                    entry_q.tile_mask <= '0;
                end else begin
                    entry_q <= entry_d;
                end
            end

            assign entry_arr[gi] = entry_q;
        end
    endgenerate

    assign rd_entry = entry_arr[rd_idx];

endmodule

// File: rtl/synchronization_core_stage2.sv
// Barrier accounting stage of the sync core (between the account arbiter and release issue).
//  clk, reset (sync, active-low)
//  ss1_account_mess/valid        in  : one account message per cycle, always accepted
//  ss2_account_pending/_valid    out : combinational copy of the input (upstream hazard check)
//  ss2_account_mess/valid        out : registered forward of the input
//  ss2_release_valid/id/cnt      out : registered; barrier completed by this arrival
//  ss2_error/ss2_error_id        out : registered one-cycle pulse on zero-count, duplicate or
//                                      count-mismatch arrival
// Same-id back-to-back messages are blocked upstream, so the table read needs no bypass.
module synchronization_core_stage2
    import npu_synchronization_defines::*;
#(
    parameter int TILE_ID        = 0,
    parameter int BARRIER_NUMBER = npu_synchronization_defines::BARRIER_NUMBER,
    parameter int TILE_COUNT     = npu_synchronization_defines::TILE_COUNT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  sync_account_message_t ss1_account_mess,
    input  logic                  ss1_account_valid,
    output sync_account_message_t ss2_account_pending,
    output logic                  ss2_account_pending_valid,
    output sync_account_message_t ss2_account_mess,
    output logic                  ss2_account_valid,
    output logic                  ss2_release_valid,
    output barrier_t              ss2_release_id,
    output cnt_barrier_t          ss2_release_cnt,
    output logic                  ss2_error,
    output barrier_t              ss2_error_id
);

    localparam int IDX_W = (BARRIER_NUMBER > 1) ? $clog2(BARRIER_NUMBER) : 1;

    // Entry types are sized by the shared package; reject a mismatched instance.
    generate
        if (TILE_ID < 0 || TILE_COUNT != $bits(tile_mask_t) ||
            BARRIER_NUMBER > (1 << BARRIER_ID_W)) begin : g_bad_cfg
            $error("synchronization_core_stage2: parameters inconsistent with package");
        end
    endgenerate

    logic [IDX_W-1:0]    idx;
    sync_barrier_entry_t rd_entry;
    logic                tbl_wr_en;
    sync_barrier_entry_t tbl_wr_entry;

    assign idx = ss1_account_mess.id_barrier[IDX_W-1:0];

    synchronization_barrier_table #(
        .BARRIER_NUMBER (BARRIER_NUMBER),
        .IDX_W          (IDX_W)
    ) u_table (
        .clk      (clk),
        .clear    (!reset),
        .rd_idx   (idx),
        .rd_entry (rd_entry),
        .wr_en    (tbl_wr_en),
        .wr_idx   (idx),
        .wr_entry (tbl_wr_entry)
    );

    logic         release_valid_q, release_valid_d;
    barrier_t     release_id_q,    release_id_d;
    cnt_barrier_t release_cnt_q,   release_cnt_d;
    logic         error_q,         error_d;
    barrier_t     error_id_q,      error_id_d;
    logic         account_valid_q;
    sync_account_message_t account_mess_q;

    cnt_barrier_t cnt_base;
    cnt_barrier_t cnt_next;
    cnt_barrier_t cnt_max_eff;

    always_comb begin
        tbl_wr_en       = 1'b0;
        tbl_wr_entry    = rd_entry;
        release_valid_d = 1'b0;
        release_id_d    = release_id_q;
        release_cnt_d   = release_cnt_q;
        error_d         = 1'b0;
        error_id_d      = error_id_q;
        cnt_base        = rd_entry.busy ? rd_entry.cnt : '0;
        cnt_next        = cnt_base + cnt_barrier_t'(1);
        // A running barrier keeps the count it was opened with, even if a later
        // arrival disagrees.
        cnt_max_eff     = rd_entry.busy ? rd_entry.cnt_max : ss1_account_mess.cnt_setup;

        if (ss1_account_valid) begin
            if (ss1_account_mess.cnt_setup == '0) begin
                error_d    = 1'b1;
                error_id_d = ss1_account_mess.id_barrier;
            end else if (rd_entry.busy &&
                         rd_entry.tile_mask[ss1_account_mess.tile_id_source]) begin
                error_d    = 1'b1;
                error_id_d = ss1_account_mess.id_barrier;
            end else begin
                if (rd_entry.busy && (ss1_account_mess.cnt_setup != rd_entry.cnt_max)) begin
                    error_d    = 1'b1;
                    error_id_d = ss1_account_mess.id_barrier;
                end
                if (cnt_next == cnt_max_eff) begin
                    release_valid_d = 1'b1;
                    release_id_d    = ss1_account_mess.id_barrier;
                    release_cnt_d   = cnt_max_eff;
                    // An idle entry completing in one pass (count of 1) needs no write.
                    if (rd_entry.busy) begin
                        tbl_wr_en              = 1'b1;
                        tbl_wr_entry.busy      = 1'b0;
                        tbl_wr_entry.cnt       = '0;
                        tbl_wr_entry.tile_mask = '0;
                    end
                end else begin
                    tbl_wr_en              = 1'b1;
                    tbl_wr_entry.busy      = 1'b1;
                    tbl_wr_entry.cnt       = cnt_next;
                    tbl_wr_entry.cnt_max   = cnt_max_eff;
                    tbl_wr_entry.tile_mask = (rd_entry.busy ? rd_entry.tile_mask : '0) |
                                             tile_onehot(ss1_account_mess.tile_id_source);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        account_mess_q <= ss1_account_mess;
        if (!reset) begin
            account_valid_q <= 1'b0;
            release_valid_q <= 1'b0;
            release_id_q    <= '0;
            release_cnt_q   <= '0;
            error_q         <= 1'b0;
            error_id_q      <= '0;
        end else begin
            account_valid_q <= ss1_account_valid;
            release_valid_q <= release_valid_d;
            release_id_q    <= release_id_d;
            release_cnt_q   <= release_cnt_d;
            error_q         <= error_d;
            error_id_q      <= error_id_d;
        end
    end

    assign ss2_account_pending       = ss1_account_mess;
    assign ss2_account_pending_valid = ss1_account_valid;
    assign ss2_account_mess          = account_mess_q;
    assign ss2_account_valid         = account_valid_q;
    assign ss2_release_valid         = release_valid_q;
    assign ss2_release_id            = release_id_q;
    assign ss2_release_cnt           = release_cnt_q;
    assign ss2_error                 = error_q;
    assign ss2_error_id              = error_id_q;

endmodule

// File: tb/tb_synchronization_core_stage2.sv
// Directed bench for synchronization_core_stage2: one task per scenario, inline checks,
// one line per transaction.
module tb_synchronization_core_stage2;
    import npu_synchronization_defines::*;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    sync_account_message_t ss1_account_mess = '0;
    logic                  ss1_account_valid = 1'b0;
    sync_account_message_t ss2_account_pending;
    logic                  ss2_account_pending_valid;
    sync_account_message_t ss2_account_mess;
    logic                  ss2_account_valid;
    logic                  ss2_release_valid;
    barrier_t              ss2_release_id;
    cnt_barrier_t          ss2_release_cnt;
    logic                  ss2_error;
    barrier_t              ss2_error_id;

    int vectors = 0;
    int miscompares = 0;

    synchronization_core_stage2 dut (
        .clk                       (clk),
        .reset                     (reset),
        .ss1_account_mess          (ss1_account_mess),
        .ss1_account_valid         (ss1_account_valid),
        .ss2_account_pending       (ss2_account_pending),
        .ss2_account_pending_valid (ss2_account_pending_valid),
        .ss2_account_mess          (ss2_account_mess),
        .ss2_account_valid         (ss2_account_valid),
        .ss2_release_valid         (ss2_release_valid),
        .ss2_release_id            (ss2_release_id),
        .ss2_release_cnt           (ss2_release_cnt),
        .ss2_error                 (ss2_error),
        .ss2_error_id              (ss2_error_id)
    );

    always #5 clk = ~clk;

    // Drive one message on a falling edge; return 1 time unit after the capturing edge.
    task automatic send(input int id, input int cnt, input int src);
        @(negedge clk);
        ss1_account_mess.id_barrier     = barrier_t'(id);
        ss1_account_mess.cnt_setup      = cnt_barrier_t'(cnt);
        ss1_account_mess.tile_id_source = tile_id_t'(src);
        ss1_account_valid               = 1'b1;
        @(posedge clk);
        #1;
        $display("txn id=%0d cnt=%0d src=%0d -> rel=%b rel_id=%0d rel_cnt=%0d err=%b err_id=%0d",
                 id, cnt, src, ss2_release_valid, ss2_release_id, ss2_release_cnt,
                 ss2_error, ss2_error_id);
    endtask

    task automatic idle();
        @(negedge clk);
        ss1_account_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({ss2_account_valid, ss2_release_valid, ss2_error} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 000", {ss2_account_valid, ss2_release_valid, ss2_error});
        end
        vectors++;
        if ({ss2_release_id, ss2_release_cnt, ss2_error_id} !== '0) begin
            miscompares++;
            $display("FAIL reset_data got %h/%h/%h want 0", ss2_release_id, ss2_release_cnt, ss2_error_id);
        end
        @(negedge clk);
        reset = 1'b1;
        idle();
    endtask

    task automatic test_three_arrivals();
        send(5, 3, 0);
        vectors++;
        if (ss2_release_valid !== 1'b0 || ss2_error !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_arr0 rel=%b err=%b want 0 0", ss2_release_valid, ss2_error);
        end
        vectors++;
        if (ss2_account_valid !== 1'b1 || ss2_account_mess.id_barrier !== 8'd5 ||
            ss2_account_mess.tile_id_source !== 3'd0) begin
            miscompares++;
            $display("FAIL t1_fwd valid=%b id=%0d src=%0d want 1 5 0", ss2_account_valid,
                     ss2_account_mess.id_barrier, ss2_account_mess.tile_id_source);
        end
        send(5, 3, 1);
        vectors++;
        if (ss2_release_valid !== 1'b0 || ss2_error !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_arr1 rel=%b err=%b want 0 0", ss2_release_valid, ss2_error);
        end
        send(5, 3, 2);
        vectors++;
        if (ss2_release_valid !== 1'b1 || ss2_release_id !== 8'd5 || ss2_release_cnt !== 4'd3 ||
            ss2_error !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_release rel=%b id=%0d cnt=%0d err=%b want 1 5 3 0", ss2_release_valid,
                     ss2_release_id, ss2_release_cnt, ss2_error);
        end
        // An idle entry 5 completes a single-participant barrier without complaint.
        send(5, 1, 0);
        vectors++;
        if (ss2_release_valid !== 1'b1 || ss2_release_cnt !== 4'd1 || ss2_error !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_idle rel=%b cnt=%0d err=%b want 1 1 0", ss2_release_valid,
                     ss2_release_cnt, ss2_error);
        end
        idle();
        vectors++;
        if (ss2_release_valid !== 1'b0 || ss2_account_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_quiet rel=%b valid=%b want 0 0", ss2_release_valid, ss2_account_valid);
        end
    endtask

    task automatic test_single_participant();
        @(negedge clk);
        ss1_account_mess.id_barrier     = 8'd2;
        ss1_account_mess.cnt_setup      = 4'd1;
        ss1_account_mess.tile_id_source = 3'd4;
        ss1_account_valid               = 1'b1;
        #1;
        vectors++;
        if (ss2_account_pending !== ss1_account_mess || ss2_account_pending_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL t2_pending got %h/%b want %h/1", ss2_account_pending,
                     ss2_account_pending_valid, ss1_account_mess);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (ss2_release_valid !== 1'b1 || ss2_release_id !== 8'd2 || ss2_release_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL t2_release rel=%b id=%0d cnt=%0d want 1 2 1", ss2_release_valid,
                     ss2_release_id, ss2_release_cnt);
        end
        // Same tile again: if entry 2 had been marked busy this would be a duplicate.
        send(2, 1, 4);
        vectors++;
        if (ss2_release_valid !== 1'b1 || ss2_error !== 1'b0) begin
            miscompares++;
            $display("FAIL t2_never_busy rel=%b err=%b want 1 0", ss2_release_valid, ss2_error);
        end
        idle();
    endtask

    task automatic test_duplicate();
        send(7, 4, 1);
        send(7, 4, 1);
        vectors++;
        if (ss2_error !== 1'b1 || ss2_error_id !== 8'd7 || ss2_release_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL t3_dup err=%b id=%0d rel=%b want 1 7 0", ss2_error, ss2_error_id,
                     ss2_release_valid);
        end
        send(7, 4, 2);
        send(7, 4, 3);
        vectors++;
        if (ss2_release_valid !== 1'b0 || ss2_error !== 1'b0) begin
            miscompares++;
            $display("FAIL t3_cnt_held rel=%b err=%b want 0 0", ss2_release_valid, ss2_error);
        end
        send(7, 4, 0);
        vectors++;
        if (ss2_release_valid !== 1'b1 || ss2_release_id !== 8'd7 || ss2_release_cnt !== 4'd4) begin
            miscompares++;
            $display("FAIL t3_release rel=%b id=%0d cnt=%0d want 1 7 4", ss2_release_valid,
                     ss2_release_id, ss2_release_cnt);
        end
        send(8, 0, 0);
        vectors++;
        if (ss2_error !== 1'b1 || ss2_error_id !== 8'd8 || ss2_release_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL t3_zero err=%b id=%0d rel=%b want 1 8 0", ss2_error, ss2_error_id,
                     ss2_release_valid);
        end
        idle();
    endtask

    task automatic test_mismatch();
        send(3, 2, 0);
        send(3, 5, 6);
        vectors++;
        if (ss2_error !== 1'b1 || ss2_error_id !== 8'd3) begin
            miscompares++;
            $display("FAIL t4_err err=%b id=%0d want 1 3", ss2_error, ss2_error_id);
        end
        vectors++;
        if (ss2_release_valid !== 1'b1 || ss2_release_id !== 8'd3 || ss2_release_cnt !== 4'd2) begin
            miscompares++;
            $display("FAIL t4_release rel=%b id=%0d cnt=%0d want 1 3 2", ss2_release_valid,
                     ss2_release_id, ss2_release_cnt);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        send(0, 2, 0);
        send(1, 2, 0);
        vectors++;
        if (ss2_release_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL t5_first rel=%b want 0", ss2_release_valid);
        end
        send(0, 2, 1);
        vectors++;
        if (ss2_release_valid !== 1'b1 || ss2_release_id !== 8'd0 || ss2_release_cnt !== 4'd2) begin
            miscompares++;
            $display("FAIL t5_rel0 rel=%b id=%0d cnt=%0d want 1 0 2", ss2_release_valid,
                     ss2_release_id, ss2_release_cnt);
        end
        send(1, 2, 1);
        vectors++;
        if (ss2_release_valid !== 1'b1 || ss2_release_id !== 8'd1 || ss2_error !== 1'b0) begin
            miscompares++;
            $display("FAIL t5_rel1 rel=%b id=%0d err=%b want 1 1 0", ss2_release_valid,
                     ss2_release_id, ss2_error);
        end
        idle();
    endtask

    task automatic test_reset_mid_barrier();
        send(9, 3, 0);
        send(9, 3, 1);
        @(negedge clk);
        reset = 1'b0;
        ss1_account_mess.tile_id_source = 3'd2;
        @(posedge clk);
        #1;
        vectors++;
        if ({ss2_account_valid, ss2_release_valid, ss2_error} !== 3'b000 ||
            ss2_release_id !== 8'd0 || ss2_release_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL t6_in_reset v/r/e=%b id=%0d cnt=%0d want 000 0 0",
                     {ss2_account_valid, ss2_release_valid, ss2_error}, ss2_release_id, ss2_release_cnt);
        end
        @(negedge clk);
        reset = 1'b1;
        ss1_account_valid = 1'b0;
        send(9, 3, 0);
        vectors++;
        if (ss2_release_valid !== 1'b0 || ss2_error !== 1'b0) begin
            miscompares++;
            $display("FAIL t6_post0 rel=%b err=%b want 0 0", ss2_release_valid, ss2_error);
        end
        send(9, 3, 1);
        vectors++;
        if (ss2_release_valid !== 1'b0 || ss2_error !== 1'b0) begin
            miscompares++;
            $display("FAIL t6_post1 rel=%b err=%b want 0 0", ss2_release_valid, ss2_error);
        end
        send(9, 3, 2);
        vectors++;
        if (ss2_release_valid !== 1'b1 || ss2_release_id !== 8'd9 || ss2_release_cnt !== 4'd3) begin
            miscompares++;
            $display("FAIL t6_release rel=%b id=%0d cnt=%0d want 1 9 3", ss2_release_valid,
                     ss2_release_id, ss2_release_cnt);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_three_arrivals();
        test_single_participant();
        test_duplicate();
        test_mismatch();
        test_back_to_back();
        test_reset_mid_barrier();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
